// File: rtl/evm_pkg.sv
// Shared types and constants for the EVM vote-tally datapath.
package evm_pkg;

   localparam int CNT_W_DEFAULT = 4;
   localparam int NUM_CAND      = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ARMED  = 2'b01,
      COMMIT = 2'b10
   } state_t;

   localparam logic [1:0] CAND_A = 2'd0;
   localparam logic [1:0] CAND_B = 2'd1;
   localparam logic [1:0] CAND_C = 2'd2;
   localparam logic [1:0] CAND_D = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && !sat) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;
   assign sat   = &count_reg;

endmodule

// File: rtl/vote_tally_demux.sv
// One-vote-per-arm ballot FSM steering increments into four saturating tallies.
// Optional arm timeout is compiled in with the VOTE_TIMEOUT_EN macro.
module vote_tally_demux
   import evm_pkg::*;
#(
   parameter int CNT_W          = CNT_W_DEFAULT,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ballot_en,
   input  logic             vote_valid,
   input  logic [1:0]       vote_sel,
   input  logic             clear_tally,
   output logic [CNT_W-1:0] A,
   output logic [CNT_W-1:0] B,
   output logic [CNT_W-1:0] C,
   output logic [CNT_W-1:0] D,
   output logic             ready,
   output logic             vote_done,
   output logic             overflow,
   output logic             timeout
);

   if (CNT_W < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
      $error("vote_tally_demux: illegal CNT_W or TIMEOUT_CYCLES");
   end

   state_t           state_reg, state_next;
   logic [1:0]       sel_reg;
   logic             ready_reg, vote_done_reg, overflow_reg;
   logic             expire;
   logic             clr_all, commit_ovf;
   logic [NUM_CAND-1:0] inc_vec, sat_vec;
   logic [CNT_W-1:0] cnt [NUM_CAND];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (!clear_tally && ballot_en) state_next = ARMED;
         ARMED:   if (vote_valid) state_next = COMMIT;
                  else if (expire) state_next = IDLE;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      clr_all    = (state_reg == IDLE) && clear_tally;
      inc_vec    = '0;
      commit_ovf = 1'b0;
      if (state_reg == COMMIT) begin
         inc_vec[sel_reg] = 1'b1;
         commit_ovf       = sat_vec[sel_reg];
      end
   end

   // Outputs come from registers so nothing on the pins is combinational in the inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_reg       <= CAND_A;
         ready_reg     <= 1'b0;
         vote_done_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         if (state_reg == ARMED && vote_valid) sel_reg <= vote_sel;
         ready_reg     <= (state_next == ARMED);
         vote_done_reg <= (state_reg == COMMIT);
         overflow_reg  <= clr_all ? 1'b0 : (overflow_reg | commit_ovf);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CAND; gi++) begin : g_tally
         sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc_vec[gi]),
            .clr   (clr_all),
            .count (cnt[gi]),
            .sat   (sat_vec[gi])
         );
      end
   endgenerate

`ifdef VOTE_TIMEOUT_EN
   logic [15:0] timer_reg;
   logic        timeout_reg;

   // Timer is zero in the first ARMED cycle, so the limit lands on ARMED cycle TIMEOUT_CYCLES.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_reg   <= '0;
         timeout_reg <= 1'b0;
      end else begin
         timer_reg   <= (state_reg == ARMED) ? timer_reg + 16'd1 : 16'd0;
         timeout_reg <= expire && !vote_valid;
      end
   end

   assign expire  = (state_reg == ARMED) && (timer_reg == 16'(TIMEOUT_CYCLES - 1));
   assign timeout = timeout_reg;
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

   assign A         = cnt[CAND_A];
   assign B         = cnt[CAND_B];
   assign C         = cnt[CAND_C];
   assign D         = cnt[CAND_D];
   assign ready     = ready_reg;
   assign vote_done = vote_done_reg;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_vote_tally_demux.sv
// Randomised self-checking bench for vote_tally_demux against a per-candidate count model.
module tb_vote_tally_demux;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ballot_en = 1'b0;
   logic       vote_valid = 1'b0;
   logic [1:0] vote_sel = 2'd0;
   logic       clear_tally = 1'b0;
   logic [3:0] A, B, C, D;
   logic       ready, vote_done, overflow, timeout;

   int checks = 0;
   int failures = 0;
   int model [4];
   logic model_ovf;

   vote_tally_demux #(.CNT_W(4), .TIMEOUT_CYCLES(10)) dut (
      .clk(clk), .rst_n(rst_n), .ballot_en(ballot_en), .vote_valid(vote_valid),
      .vote_sel(vote_sel), .clear_tally(clear_tally), .A(A), .B(B), .C(C), .D(D),
      .ready(ready), .vote_done(vote_done), .overflow(overflow), .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] get_tally(int i);
      case (i)
         0: return A;
         1: return B;
         2: return C;
         default: return D;
      endcase
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 4; i++) model[i] = 0;
      model_ovf = 1'b0;
   endfunction

   function automatic void model_vote(int s);
      if (model[s] == 15) model_ovf = 1'b1;
      else model[s] = model[s] + 1;
   endfunction

   // Full ballot: arm, wait gap cycles, vote, then watch three cycles for vote_done.
   task automatic cast_vote(input logic [1:0] s, input int gap, output int pulses, output logic armed_ready);
      ballot_en = 1'b1;
      step;
      ballot_en = 1'b0;
      armed_ready = ready;
      repeat (gap) step;
      vote_valid = 1'b1;
      vote_sel = s;
      step;
      vote_valid = 1'b0;
      pulses = 0;
      repeat (3) begin
         if (vote_done) pulses++;
         step;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) step;
      checks++;
      if ({A, B, C, D, ready, vote_done, overflow, timeout} !== 20'd0) begin
         failures++;
         $display("FAIL reset_hold: got %h required 0", {A, B, C, D, ready, vote_done, overflow, timeout});
      end
      rst_n = 1'b1;
      step;
      checks++;
      if ({A, B, C, D, ready, vote_done, overflow, timeout} !== 20'd0) begin
         failures++;
         $display("FAIL reset_idle: got %h required 0", {A, B, C, D, ready, vote_done, overflow, timeout});
      end
      model_clear();
   endtask

   task automatic test_basic;
      ballot_en = 1'b1;
      step;
      ballot_en = 1'b0;
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL basic_ready: got %b required 1", ready); end
      vote_valid = 1'b1;
      vote_sel = 2'd2;
      step;
      vote_valid = 1'b0;
      checks++;
      if ({ready, vote_done, C} !== 6'd0) begin
         failures++;
         $display("FAIL basic_commit_cycle: ready/done/C got %b/%b/%0d required 0/0/0", ready, vote_done, C);
      end
      step;
      model_vote(2);
      checks++;
      if (vote_done !== 1'b1) begin failures++; $display("FAIL basic_done: got %b required 1", vote_done); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (get_tally(i) !== 4'(model[i])) begin
            failures++;
            $display("FAIL basic_tally%0d: got %0d required %0d", i, get_tally(i), model[i]);
         end
      end
      step;
      checks++;
      if (vote_done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b required 0", vote_done); end
   endtask

   task automatic test_double_vote;
      int pulses = 0;
      int ready_seen = 0;
      ballot_en = 1'b1;
      step;
      ballot_en = 1'b0;
      vote_valid = 1'b1;
      vote_sel = 2'd1;
      for (int k = 0; k < 8; k++) begin
         step;
         if (k == 4) vote_valid = 1'b0;
         if (vote_done) pulses++;
      end
      model_vote(1);
      checks++;
      if (pulses != 1) begin failures++; $display("FAIL double_pulses: got %0d required 1", pulses); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (get_tally(i) !== 4'(model[i])) begin
            failures++;
            $display("FAIL double_tally%0d: got %0d required %0d", i, get_tally(i), model[i]);
         end
      end
      pulses = 0;
      vote_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         vote_sel = 2'($urandom_range(0, 3));
         step;
         if (vote_done) pulses++;
         if (ready) ready_seen++;
      end
      vote_valid = 1'b0;
      step;
      checks++;
      if (pulses != 0 || ready_seen != 0) begin
         failures++;
         $display("FAIL unarmed_vote: done/ready cycles got %0d/%0d required 0/0", pulses, ready_seen);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (get_tally(i) !== 4'(model[i])) begin
            failures++;
            $display("FAIL unarmed_tally%0d: got %0d required %0d", i, get_tally(i), model[i]);
         end
      end
   endtask

   task automatic test_saturation;
      int pulses;
      logic rdy;
      clear_tally = 1'b1;
      step;
      clear_tally = 1'b0;
      model_clear();
      checks++;
      if ({A, B, C, D, overflow} !== 17'd0) begin
         failures++;
         $display("FAIL sat_preclear: got %h required 0", {A, B, C, D, overflow});
      end
      for (int v = 1; v <= 16; v++) begin
         cast_vote(2'd3, 0, pulses, rdy);
         model_vote(3);
         checks++;
         if (D !== 4'(model[3]) || overflow !== model_ovf || pulses != 1) begin
            failures++;
            $display("FAIL sat_vote%0d: D/ovf/pulses got %0d/%b/%0d required %0d/%b/1",
                     v, D, overflow, pulses, model[3], model_ovf);
         end
      end
      step;
      checks++;
      if (overflow !== 1'b1) begin failures++; $display("FAIL sat_sticky: got %b required 1", overflow); end
      // clear and arm together: clear wins and the FSM stays idle
      clear_tally = 1'b1;
      ballot_en = 1'b1;
      step;
      clear_tally = 1'b0;
      ballot_en = 1'b0;
      model_clear();
      checks++;
      if ({A, B, C, D, overflow, ready} !== 18'd0) begin
         failures++;
         $display("FAIL sat_clear: got %h required 0", {A, B, C, D, overflow, ready});
      end
   endtask

   task automatic test_clear_in_armed;
      int pulses;
      logic rdy;
      cast_vote(2'd0, 0, pulses, rdy);
      model_vote(0);
      ballot_en = 1'b1;
      step;
      ballot_en = 1'b0;
      clear_tally = 1'b1;
      step;
      clear_tally = 1'b0;
      checks++;
      if (ready !== 1'b1 || A !== 4'(model[0])) begin
         failures++;
         $display("FAIL armed_clear: ready/A got %b/%0d required 1/%0d", ready, A, model[0]);
      end
      vote_valid = 1'b1;
      vote_sel = 2'd0;
      step;
      vote_valid = 1'b0;
      step;
      model_vote(0);
      checks++;
      if (A !== 4'(model[0]) || vote_done !== 1'b1) begin
         failures++;
         $display("FAIL armed_clear_vote: A/done got %0d/%b required %0d/1", A, vote_done, model[0]);
      end
      step;
   endtask

   task automatic test_random;
      int pulses;
      logic rdy;
      logic [1:0] s;
      int gap;
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 9) == 0) begin
            clear_tally = 1'b1;
            step;
            clear_tally = 1'b0;
            model_clear();
            $display("txn %0d clear", t);
         end else begin
            s = 2'($urandom_range(0, 3));
            gap = $urandom_range(0, 4);
            cast_vote(s, gap, pulses, rdy);
            model_vote(s);
            $display("txn %0d vote sel=%0d gap=%0d tallies=%0d,%0d,%0d,%0d ovf=%b", t, s, gap, A, B, C, D, overflow);
            checks++;
            if (pulses != 1 || rdy !== 1'b1) begin
               failures++;
               $display("FAIL rand%0d_handshake: pulses/ready got %0d/%b required 1/1", t, pulses, rdy);
            end
         end
         checks++;
         if (A !== 4'(model[0]) || B !== 4'(model[1]) || C !== 4'(model[2]) ||
             D !== 4'(model[3]) || overflow !== model_ovf) begin
            failures++;
            $display("FAIL rand%0d_tally: got %0d,%0d,%0d,%0d ovf=%b required %0d,%0d,%0d,%0d ovf=%b", t,
                     A, B, C, D, overflow, model[0], model[1], model[2], model[3], model_ovf);
         end
      end
   endtask

   task automatic test_reset_mid;
      int pulses = 0;
      ballot_en = 1'b1;
      step;
      ballot_en = 1'b0;
      vote_valid = 1'b1;
      vote_sel = 2'd0;
      step;
      vote_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      model_clear();
      checks++;
      if ({A, B, C, D, ready, vote_done, overflow} !== 19'd0) begin
         failures++;
         $display("FAIL reset_async: got %h required 0", {A, B, C, D, ready, vote_done, overflow});
      end
      step;
      step;
      rst_n = 1'b1;
      repeat (4) begin
         step;
         if (vote_done || ready) pulses++;
      end
      checks++;
      if (pulses != 0 || A !== 4'd0) begin
         failures++;
         $display("FAIL reset_mid: active cycles/A got %0d/%0d required 0/0", pulses, A);
      end
   endtask

`ifdef VOTE_TIMEOUT_EN
   task automatic test_timeout;
      int armed_cycles = 0;
      int tpulses = 0;
      logic [1:0] s;
      ballot_en = 1'b1;
      step;
      ballot_en = 1'b0;
      while (ready && armed_cycles < 40) begin
         armed_cycles++;
         step;
      end
      checks++;
      if (armed_cycles != 10 || timeout !== 1'b1) begin
         failures++;
         $display("FAIL timeout_expiry: armed cycles/timeout got %0d/%b required 10/1", armed_cycles, timeout);
      end
      step;
      checks++;
      if (timeout !== 1'b0 || {A, B, C, D} !== {4'(model[0]), 4'(model[1]), 4'(model[2]), 4'(model[3])}) begin
         failures++;
         $display("FAIL timeout_after: timeout got %b required 0 or tallies changed", timeout);
      end
      s = 2'($urandom_range(0, 3));
      ballot_en = 1'b1;
      step;
      ballot_en = 1'b0;
      repeat (9) step;
      vote_valid = 1'b1;
      vote_sel = s;
      step;
      vote_valid = 1'b0;
      if (timeout) tpulses++;
      step;
      if (timeout) tpulses++;
      model_vote(s);
      checks++;
      if (tpulses != 0 || vote_done !== 1'b1 || get_tally(s) !== 4'(model[s])) begin
         failures++;
         $display("FAIL timeout_race: timeout/done/tally got %0d/%b/%0d required 0/1/%0d",
                  tpulses, vote_done, get_tally(s), model[s]);
      end
      step;
   endtask
`else
   task automatic test_timeout;
      int tpulses = 0;
      ballot_en = 1'b1;
      step;
      ballot_en = 1'b0;
      repeat (30) begin
         step;
         if (timeout) tpulses++;
      end
      checks++;
      if (tpulses != 0 || ready !== 1'b1) begin
         failures++;
         $display("FAIL no_timeout: timeout/ready got %0d/%b required 0/1", tpulses, ready);
      end
      vote_valid = 1'b1;
      vote_sel = 2'd1;
      step;
      vote_valid = 1'b0;
      step;
      model_vote(1);
      checks++;
      if (B !== 4'(model[1]) || vote_done !== 1'b1) begin
         failures++;
         $display("FAIL no_timeout_vote: B/done got %0d/%b required %0d/1", B, vote_done, model[1]);
      end
      step;
   endtask
`endif

   initial begin
      model_clear();
      test_reset();
      test_basic();
      test_double_vote();
      test_saturation();
      test_clear_in_armed();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
